// File: rtl/div_hilo_unit.sv
// Iterative restoring divider with HI/LO result registers and a datapath stall.
// One quotient bit per clock, followed by a sign-correction cycle that writes HI/LO.
module div_hilo_unit #(
    parameter int unsigned WIDTH  = 32,
    parameter bit          SIGNED = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             isDiv,
    input  logic             ismfhi,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] hilo_out,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] hi, lo;
    logic [WIDTH-1:0] rem, quo, dvsr, raw_dividend;
    logic [CW-1:0]    counter;
    logic             neg_q, neg_r, dvsr_zero;

    logic             dividend_neg, divisor_neg;
    logic [WIDTH-1:0] dividend_mag, divisor_mag;
    logic [WIDTH:0]   rem_shift, rem_diff;
    logic             ge;
    logic [WIDTH-1:0] rem_next;

    always_comb begin
        dividend_neg = SIGNED && dividend[WIDTH-1];
        divisor_neg  = SIGNED && divisor[WIDTH-1];
        dividend_mag = dividend_neg ? ('0 - dividend) : dividend;
        divisor_mag  = divisor_neg  ? ('0 - divisor)  : divisor;
    end

    // rem < dvsr holds for a nonzero divisor, so the borrow bit alone decides the compare;
    // the zero-divisor result is replaced wholesale in FIX.
    always_comb begin
        rem_shift = {rem, quo[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, dvsr};
        ge        = ~rem_diff[WIDTH];
        rem_next  = ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (isDiv) state_next = S_RUN;
            S_RUN:   if (counter == CW'(1)) state_next = S_FIX;
            S_FIX:   state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        hilo_out = ismfhi ? hi : lo;
        busy     = (state != S_IDLE);
        done     = (state == S_DONE);
        stall    = ((state == S_IDLE) && isDiv) || (state == S_RUN) || (state == S_FIX);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            hi           <= '0;
            lo           <= '0;
            rem          <= '0;
            quo          <= '0;
            dvsr         <= '0;
            raw_dividend <= '0;
            counter      <= '0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            dvsr_zero    <= 1'b0;
            div_by_zero  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (isDiv) begin
                        rem          <= '0;
                        quo          <= dividend_mag;
                        dvsr         <= divisor_mag;
                        raw_dividend <= dividend;
                        counter      <= CW'(WIDTH);
                        neg_q        <= dividend_neg ^ divisor_neg;
                        neg_r        <= dividend_neg;
                        dvsr_zero    <= (divisor == '0);
                        div_by_zero  <= 1'b0;
                    end
                end
                S_RUN: begin
                    rem     <= rem_next;
                    quo     <= {quo[WIDTH-2:0], ge};
                    counter <= counter - CW'(1);
                end
                S_FIX: begin
                    if (dvsr_zero) begin
                        lo          <= '1;
                        hi          <= raw_dividend;
                        div_by_zero <= 1'b1;
                    end else begin
                        lo <= neg_q ? ('0 - quo) : quo;
                        hi <= neg_r ? ('0 - rem) : rem;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_hilo_unit.sv
// Scoreboard bench for div_hilo_unit: the driver queues expected HI/LO per DIV,
// a monitor checks them on each done pulse together with the stall length.
module tb_div_hilo_unit;

    localparam int unsigned W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic         isDiv;
    logic         ismfhi;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] hilo_out;
    logic         stall;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         dbz;
        logic         mfhi;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] prev_hi = '0;
    logic [W-1:0] prev_lo = '0;

    div_hilo_unit #(.WIDTH(W), .SIGNED(1'b1)) dut (
        .clock       (clock),
        .reset       (reset),
        .isDiv       (isDiv),
        .ismfhi      (ismfhi),
        .dividend    (dividend),
        .divisor     (divisor),
        .hilo_out    (hilo_out),
        .stall       (stall),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: counts stall cycles and checks results on every done pulse.
    initial begin : monitor
        int   stall_cnt;
        exp_t e;
        stall_cnt = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                stall_cnt = 0;
            end else begin
                if (stall) stall_cnt++;
                if (done) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got done=1 expected no pulse");
                    end else begin
                        e = sb.pop_front();
                        check("stall_cycles", W'(stall_cnt), W'(W + 2));
                        check("stall_in_done", {31'b0, stall}, 32'd0);
                        check("result_sel", hilo_out, e.mfhi ? e.hi : e.lo);
                        check("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.dbz});
                    end
                    stall_cnt = 0;
                end
            end
        end
    end

    task automatic wait_done(input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done expected done within 60 cycles", name);
        end
    endtask

    task automatic run_div(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic mfhi, input logic [W-1:0] exp_lo,
                           input logic [W-1:0] exp_hi, input logic exp_dbz);
        exp_t e;
        e.lo = exp_lo; e.hi = exp_hi; e.dbz = exp_dbz; e.mfhi = mfhi;
        sb.push_back(e);
        @(posedge clock); #1;
        isDiv = 1'b1; dividend = a; divisor = b; ismfhi = mfhi;
        @(negedge clock);
        check({name, "_start_stall"}, {31'b0, stall}, 32'd1);
        check({name, "_start_hilo"}, hilo_out, mfhi ? prev_hi : prev_lo);
        @(posedge clock); #1;
        isDiv = 1'b0;
        @(negedge clock);
        check({name, "_run_busy"}, {31'b0, busy}, 32'd1);
        check({name, "_run_dbz_clear"}, {31'b0, div_by_zero}, 32'd0);
        check({name, "_run_hilo_prev"}, hilo_out, mfhi ? prev_hi : prev_lo);
        wait_done(name);
        prev_hi = exp_hi;
        prev_lo = exp_lo;
        @(posedge clock); #1;
        ismfhi = ~mfhi;
        @(negedge clock);
        check({name, "_other_sel"}, hilo_out, mfhi ? exp_lo : exp_hi);
        check({name, "_idle_busy"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin : driver
        exp_t e;
        reset = 1'b1; isDiv = 1'b0; ismfhi = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clock);
        #1;
        @(negedge clock);
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_dbz", {31'b0, div_by_zero}, 32'd0);
        check("rst_lo", hilo_out, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        run_div("d100_7",   32'd100,        32'd7,          1'b1, 32'd14,         32'd2,          1'b0);
        run_div("dm7_2",    32'hFFFF_FFF9,  32'd2,          1'b0, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0);
        run_div("d7_m2",    32'd7,          32'hFFFF_FFFE,  1'b0, 32'hFFFF_FFFD,  32'd1,          1'b0);
        run_div("dm100_m7", 32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b1, 32'd14,         32'hFFFF_FFFE,  1'b0);
        run_div("d5_0",     32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5,          1'b1);
        repeat (3) @(negedge clock);
        check("dbz_held", {31'b0, div_by_zero}, 32'd1);
        run_div("d9_3",     32'd9,          32'd3,          1'b0, 32'd3,          32'd0,          1'b0);
        run_div("dovf",     32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'h8000_0000,  32'd0,          1'b0);

        // isDiv held across the whole division: one result, restart only in the next IDLE.
        e.lo = 32'd14; e.hi = 32'd2; e.dbz = 1'b0; e.mfhi = 1'b0;
        sb.push_back(e);
        @(posedge clock); #1;
        isDiv = 1'b1; dividend = 32'd100; divisor = 32'd7; ismfhi = 1'b0;
        begin
            int cyc;
            cyc = -1;
            for (int i = 0; i < 60; i++) begin
                @(negedge clock);
                if (done) begin
                    cyc = i;
                    break;
                end
            end
            check("held_done_cycle", W'(cyc), W'(W + 2));
        end
        sb.push_back(e);
        @(negedge clock);
        check("held_restart_stall", {31'b0, stall}, 32'd1);
        check("held_restart_idle", {31'b0, busy}, 32'd0);
        @(posedge clock); #1;
        isDiv = 1'b0;
        wait_done("held_second");
        prev_hi = 32'd2;
        prev_lo = 32'd14;

        // Reset during RUN cycle 10 aborts and clears HI/LO without a done pulse.
        @(posedge clock); #1;
        isDiv = 1'b1; dividend = 32'd100; divisor = 32'd7; ismfhi = 1'b1;
        @(posedge clock); #1;
        isDiv = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_stall", {31'b0, stall}, 32'd0);
        check("abort_hi", hilo_out, 32'd0);
        @(posedge clock); #1;
        ismfhi = 1'b0;
        @(negedge clock);
        check("abort_lo", hilo_out, 32'd0);
        repeat (40) @(negedge clock);
        check("scoreboard_empty", W'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
